// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the MIPS execute stage.
//   WORD_W    : datapath width in bits.
//   alu_op_t  : 4-bit ALU operation select.
package mips_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_NOR  = 4'd3,
    ALU_ADD  = 4'd4,
    ALU_SUB  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_SLLV = 4'd11,
    ALU_SRLV = 4'd12,
    ALU_SRAV = 4'd13,
    ALU_LUI  = 4'd14,
    ALU_PASS = 4'd15
  } alu_op_t;

endpackage

// File: rtl/alu_core.sv
// alu_core
// Purely combinational 32-bit integer ALU.
//   op1      in  : operand 1 (also supplies the variable shift amount)
//   op2      in  : operand 2 (the value being shifted for shift ops)
//   alu_op   in  : operation select, see mips_pkg::alu_op_t
//   shamt    in  : immediate shift amount
//   result   out : ALU result
//   zero     out : result == 0
//   overflow out : signed overflow, ADD/SUB only
module alu_core
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] op1,
  input  logic [WORD_W-1:0] op2,
  input  logic [3:0]        alu_op,
  input  logic [4:0]        shamt,
  output logic [WORD_W-1:0] result,
  output logic              zero,
  output logic              overflow
);

  logic [WORD_W-1:0] sum;
  logic [WORD_W-1:0] diff;
  logic [4:0]        vshamt;

  assign sum    = op1 + op2;
  assign diff   = op1 - op2;
  assign vshamt = op1[4:0];

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_op_t'(alu_op))
      ALU_AND:  result = op1 & op2;
      ALU_OR:   result = op1 | op2;
      ALU_XOR:  result = op1 ^ op2;
      ALU_NOR:  result = ~(op1 | op2);
      ALU_ADD: begin
        result   = sum;
        // Same-sign operands producing a result of the other sign.
        overflow = (op1[WORD_W-1] == op2[WORD_W-1]) &&
                   (sum[WORD_W-1] != op1[WORD_W-1]);
      end
      ALU_SUB: begin
        result   = diff;
        // Opposite-sign operands where the result sign leaves op1's sign.
        overflow = (op1[WORD_W-1] != op2[WORD_W-1]) &&
                   (diff[WORD_W-1] != op1[WORD_W-1]);
      end
      ALU_SLT:  result = {{(WORD_W-1){1'b0}}, ($signed(op1) < $signed(op2))};
      ALU_SLTU: result = {{(WORD_W-1){1'b0}}, (op1 < op2)};
      ALU_SLL:  result = op2 << shamt;
      ALU_SRL:  result = op2 >> shamt;
      ALU_SRA:  result = $signed(op2) >>> shamt;
      ALU_SLLV: result = op2 << vshamt;
      ALU_SRLV: result = op2 >> vshamt;
      ALU_SRAV: result = $signed(op2) >>> vshamt;
      ALU_LUI:  result = {op2[15:0], 16'h0000};
      ALU_PASS: result = op1;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/exe_branch_alu.sv
// exe_branch_alu
// Execute-stage compute block: ALU, branch-target adder and beq/bne
// taken decision, all captured in one output register feeding MEM.
// There is no handshake: en=1 loads the register, en=0 holds it, and
// rst (synchronous, active high) clears it with priority over en.
//   clk, rst, en          : clock, reset, register load enable
//   op1, op2, alu_op, shamt : ALU operands and control
//   pc_plus4, imm_ext     : branch target inputs
//   branch_eq, branch_ne  : instruction is beq / bne
//   result, zero, overflow, branch_addr, pc_src : registered outputs
module exe_branch_alu
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_op,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic [WIDTH-1:0] imm_ext,
  input  logic             branch_eq,
  input  logic             branch_ne,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] branch_addr,
  output logic             pc_src
);

  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic             overflow_d, overflow_q;
  logic [WIDTH-1:0] branch_addr_d, branch_addr_q;
  logic             pc_src_d, pc_src_q;

  alu_core u_alu_core (
    .op1      (op1),
    .op2      (op2),
    .alu_op   (alu_op),
    .shamt    (shamt),
    .result   (result_d),
    .zero     (zero_d),
    .overflow (overflow_d)
  );

  // Word offset to byte offset; the top two offset bits fall off, so the
  // sum wraps silently.
  assign branch_addr_d = pc_plus4 + {imm_ext[WIDTH-3:0], 2'b00};

  // Both flags set makes the decision taken whatever the zero flag is.
  assign pc_src_d = (branch_eq & zero_d) | (branch_ne & ~zero_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q      <= '0;
      zero_q        <= 1'b0;
      overflow_q    <= 1'b0;
      branch_addr_q <= '0;
      pc_src_q      <= 1'b0;
    end else if (en) begin
      result_q      <= result_d;
      zero_q        <= zero_d;
      overflow_q    <= overflow_d;
      branch_addr_q <= branch_addr_d;
      pc_src_q      <= pc_src_d;
    end
  end

  assign result      = result_q;
  assign zero        = zero_q;
  assign overflow    = overflow_q;
  assign branch_addr = branch_addr_q;
  assign pc_src      = pc_src_q;

endmodule

// File: tb/tb_exe_branch_alu.sv
module tb_exe_branch_alu;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [31:0] op1 = '0, op2 = '0, pc_plus4 = '0, imm_ext = '0;
  logic [3:0]  alu_op = '0;
  logic [4:0]  shamt = '0;
  logic        branch_eq = 1'b0, branch_ne = 1'b0;

  logic [31:0] result, branch_addr;
  logic        zero, overflow, pc_src;

  always #5 clk = ~clk;

  exe_branch_alu #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .op1         (op1),
    .op2         (op2),
    .alu_op      (alu_op),
    .shamt       (shamt),
    .pc_plus4    (pc_plus4),
    .imm_ext     (imm_ext),
    .branch_eq   (branch_eq),
    .branch_ne   (branch_ne),
    .result      (result),
    .zero        (zero),
    .overflow    (overflow),
    .branch_addr (branch_addr),
    .pc_src      (pc_src)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Packed expected outputs: {result, zero, overflow, branch_addr, pc_src}
  function automatic logic [66:0] model_next(
    input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
    input logic [4:0] sh, input logic [31:0] pc, input logic [31:0] imm,
    input logic beq, input logic bne);
    logic [31:0] r;
    logic        ov;
    longint      wide;
    int          sa, sb;
    int unsigned ua, ub;
    logic [31:0] ba;
    logic        taken;
    r = 0; ov = 0;
    sa = a; sb = b; ua = a; ub = b;
    case (op)
      0: r = a & b;
      1: r = a | b;
      2: r = a ^ b;
      3: r = ~(a | b);
      4: begin
        wide = longint'(sa) + longint'(sb);
        r = wide[31:0];
        ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      5: begin
        wide = longint'(sa) - longint'(sb);
        r = wide[31:0];
        ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      6: r = (sa < sb) ? 32'd1 : 32'd0;
      7: r = (ua < ub) ? 32'd1 : 32'd0;
      8: r = b * (32'd1 << sh);
      9: r = ub / (32'd1 << sh);
      10: r = sb >>> sh;
      11: r = b * (32'd1 << a[4:0]);
      12: r = ub / (32'd1 << a[4:0]);
      13: r = sb >>> a[4:0];
      14: r = (b % 32'h10000) * 32'h10000;
      default: r = a;
    endcase
    ba = pc + imm * 4;
    taken = (beq && r == 0) || (bne && r != 0);
    return {r, (r == 0), ov, ba, taken};
  endfunction

  // ---------------- scoreboard ----------------
  logic [66:0] exp_q[$];
  logic [66:0] mdl = '0;

  always @(posedge clk) begin
    if (rst) mdl = '0;
    else if (en) mdl = model_next(alu_op, op1, op2, shamt, pc_plus4, imm_ext, branch_eq, branch_ne);
    exp_q.push_back(mdl);
  end

  always @(negedge clk) begin
    logic [66:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("m_result", result, e[66:35]);
      chk("m_zero", {31'd0, zero}, {31'd0, e[34]});
      chk("m_overflow", {31'd0, overflow}, {31'd0, e[33]});
      chk("m_branch_addr", branch_addr, e[32:1]);
      chk("m_pc_src", {31'd0, pc_src}, {31'd0, e[0]});
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] pc, input logic [31:0] imm,
                       input logic beq, input logic bne);
    @(negedge clk);
    alu_op = op; op1 = a; op2 = b; shamt = sh;
    pc_plus4 = pc; imm_ext = imm; branch_eq = beq; branch_ne = bne;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vec_a [6] = '{32'h0000_0002, 32'h8000_0000, 32'hFFFF_FFFF,
                             32'h7FFF_FFFF, 32'h1234_5678, 32'h0000_0000};
  logic [31:0] vec_b [6] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001,
                             32'hFFFF_FFFF, 32'h8765_4321, 32'h0000_0000};
  logic [31:0] held;

  initial begin
    // reset
    drive(4'd4, 32'd9, 32'd9, 5'd3, 32'd100, 32'd5, 1'b1, 1'b1);
    drive(4'd4, 32'd9, 32'd9, 5'd3, 32'd100, 32'd5, 1'b1, 1'b1);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", {31'd0, zero}, 32'h0);
    chk("rst_baddr", branch_addr, 32'h0);
    chk("rst_pc_src", {31'd0, pc_src}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    drive(4'd4, 32'd2, 32'd3, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("add_result", result, 32'd5);
    chk("add_zero", {31'd0, zero}, 32'd0);
    chk("add_ovf", {31'd0, overflow}, 32'd0);

    drive(4'd5, 32'd3, 32'd5, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("sub_result", result, 32'hFFFF_FFFE);
    chk("sub_ovf", {31'd0, overflow}, 32'd0);

    drive(4'd4, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("addovf_result", result, 32'h8000_0000);
    chk("addovf_ovf", {31'd0, overflow}, 32'd1);

    drive(4'd5, 32'h8000_0000, 32'd1, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("subovf_result", result, 32'h7FFF_FFFF);
    chk("subovf_ovf", {31'd0, overflow}, 32'd1);

    drive(4'd5, 32'd10, 32'd10, 5'd0, 32'd204, 32'hFFFF_FFFF, 1'b1, 1'b0);
    chk("beq_zero", {31'd0, zero}, 32'd1);
    chk("beq_pc_src", {31'd0, pc_src}, 32'd1);
    chk("beq_baddr", branch_addr, 32'd200);

    drive(4'd5, 32'd10, 32'd10, 5'd0, 32'd204, 32'hFFFF_FFFF, 1'b0, 1'b1);
    chk("bne_pc_src", {31'd0, pc_src}, 32'd0);

    drive(4'd5, 32'd10, 32'd11, 5'd0, 32'd204, 32'hFFFF_FFFF, 1'b1, 1'b1);
    chk("both_pc_src", {31'd0, pc_src}, 32'd1);

    drive(4'd9, 32'd0, 32'h8000_0000, 5'd4, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("srl_result", result, 32'h0800_0000);
    drive(4'd10, 32'd0, 32'h8000_0000, 5'd4, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("sra_result", result, 32'hF800_0000);
    drive(4'd8, 32'd0, 32'd1, 5'd4, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("sll_result", result, 32'h0000_0010);
    drive(4'd13, 32'h0000_0024, 32'h8000_0000, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("srav_result", result, 32'hF800_0000);
    drive(4'd14, 32'd0, 32'hABCD_1234, 5'd0, 32'hFFFF_FFFC, 32'd2, 1'b0, 1'b0);
    chk("lui_result", result, 32'h1234_0000);
    chk("wrap_baddr", branch_addr, 32'h0000_0004);
    drive(4'd6, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("slt_result", result, 32'd1);
    drive(4'd7, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("sltu_result", result, 32'd0);
    chk("sltu_pc_src", {31'd0, pc_src}, 32'd1);

    // sweep every op over a small operand table; checked by the model
    for (int op = 0; op < 16; op++) begin
      for (int v = 0; v < 6; v++) begin
        drive(op[3:0], vec_a[v], vec_b[v], 5'(v * 7), vec_a[(v + 1) % 6], vec_b[(v + 2) % 6],
              v[0], v[1]);
      end
    end

    // hold
    drive(4'd2, 32'h0F0F_0F0F, 32'h00FF_00FF, 5'd0, 32'd64, 32'd3, 1'b0, 1'b1);
    held = result;
    chk("pre_hold", held, 32'h0FF0_0FF0);
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'd4, 32'd1 + i, 32'd7, 5'd1, 32'd8, 32'd1, 1'b1, 1'b0);
      chk("hold_result", result, 32'h0FF0_0FF0);
      chk("hold_baddr", branch_addr, 32'd76);
      chk("hold_pc_src", {31'd0, pc_src}, 32'd1);
    end

    // reset mid-stream with en=1
    @(negedge clk);
    en = 1'b1;
    rst = 1'b1;
    drive(4'd4, 32'h7FFF_FFFF, 32'd1, 5'd3, 32'd400, 32'd9, 1'b0, 1'b1);
    chk("mrst_result", result, 32'h0);
    chk("mrst_ovf", {31'd0, overflow}, 32'h0);
    chk("mrst_baddr", branch_addr, 32'h0);
    chk("mrst_pc_src", {31'd0, pc_src}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'd15, 32'hCAFE_F00D, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("pass_result", result, 32'hCAFE_F00D);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_branch_alu.md
# exe_branch_alu

Execute-stage compute block of the five-stage MIPS pipeline. It contains three parts:
- a 32-bit integer ALU;
- the branch-target adder;
- the beq/bne taken decision.

All results are captured in an output register that feeds the MEM stage. It sits between the forwarding operand muxes and the EXE/MEM pipeline register fields for result, zero, branch address and PC-source.

## Interface
Parameters:
- `WIDTH`, 32: datapath width (only 32 is supported).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: when 1, the output register loads; when 0, it holds.
- `op1` input 32: ALU operand 1 (forwarded Rs).
- `op2` input 32: ALU operand 2 (forwarded Rt or extended immediate).
- `alu_op` input 4: operation select.
- `shamt` input 5: shift amount for the immediate-shift ops.
- `pc_plus4` input 32: PC+4 of the instruction in EXE.
- `imm_ext` input 32: sign-extended 16-bit branch offset.
- `branch_eq` input 1: the instruction is beq.
- `branch_ne` input 1: the instruction is bne.
- `result` output 32: registered ALU result.
- `zero` output 1: registered; 1 when the ALU result is 0.
- `overflow` output 1: registered signed overflow flag.
- `branch_addr` output 32: registered branch target.
- `pc_src` output 1: registered branch-taken flag.

## Operation
ALU operation encoding (`alu_op`):
- 0 AND
- 1 OR
- 2 XOR
- 3 NOR
- 4 ADD: op1+op2
- 5 SUB: op1−op2
- 6 SLT: signed compare, result 1 or 0
- 7 SLTU: unsigned compare, result 1 or 0
- 8 SLL: op2<<shamt
- 9 SRL: op2>>shamt, logical
- 10 SRA: op2>>>shamt, arithmetic
- 11 SLLV: op2<<op1[4:0]
- 12 SRLV: op2>>op1[4:0], logical
- 13 SRAV: op2>>>op1[4:0], arithmetic
- 14 LUI: {op2[15:0], 16'h0}
- 15 PASS: result = op1

Arithmetic and width rules:
- ADD and SUB wrap modulo 2^32; no exception and no trap.
- `overflow` is 1 only for ADD/SUB when the signed result overflows:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from op1.
- `overflow` is 0 for every other op.
- `zero` = (ALU result == 0), evaluated for every op.

Branch target and decision:
- `branch_addr` = pc_plus4 + (imm_ext << 2), modulo 2^32. Wrap-around is silent.
- The target is computed regardless of the branch flags.
- `pc_src` = (branch_eq & zero_next) | (branch_ne & ~zero_next). `zero_next` is the unregistered zero of the current op.
- If both `branch_eq` and `branch_ne` are 1, `pc_src` = 1.

## Timing
- All five outputs are registered; latency from inputs to outputs is 1 clock.
- Reset value of every output is 0: result, zero, overflow, branch_addr, pc_src.
- Reset takes priority over `en`. Asserting `rst` mid-stream clears the outputs on the next edge, and the in-flight op is lost.
- `en`=0 holds all outputs unchanged. It has no effect while `rst`=1.
- No handshake and no internal state beyond the output register.
- Combinational paths are input → register only; there are no input-to-output combinational paths.

## Structure
- Shared package `mips_pkg`:
  - `alu_op_t` enum with the 16 encodings above.
  - `WORD_W` = 32.
- Sub-module `alu_core`: purely combinational. Inputs op1, op2, alu_op, shamt; outputs result, zero, overflow.
- The top level adds:
  - the branch-target adder;
  - the eq/ne taken logic;
  - the output register.

## Test plan
- ADD, op1=2, op2=3, alu_op=4 → after one edge result=5, zero=0, overflow=0.
- SUB, op1=3, op2=5 → result=0xFFFFFFFE (−2), overflow=0.
- ADD overflow: 0x7FFFFFFF+1 → result=0x80000000, overflow=1.
- SUB, op1=op2=10, branch_eq=1, pc_plus4=204, imm_ext=0xFFFFFFFF → zero=1, pc_src=1, branch_addr=200.
- Same inputs with branch_eq=0, branch_ne=1 → pc_src=0.
- Shifts, op2=0x80000000, shamt=4:
  - SRL → 0x08000000
  - SRA → 0xF8000000
  - SLL of 1 → 0x10.
- Hold and reset:
  - `en`=0 → outputs held across 3 edges.
  - `rst`=1 while `en`=1 with nonzero inputs → all outputs 0 on the next edge.
